// File: rtl/qa_drv_pkg.sv
// qa_drv_pkg: shared types and defaults for the qa_drv write path.
package qa_drv_pkg;
    typedef enum logic {ARB, FENCE_WAIT} t_WR_SCHED_STATE;
    localparam int QA_DRV_MAX_OUTSTANDING = 64;
endpackage

// File: rtl/qa_drv_rr_picker.sv
// qa_drv_rr_picker: one-hot round-robin pick, searching upward from last+1.
module qa_drv_rr_picker #(
    parameter int N  = 3,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt
);
    always_comb begin
        int idx;
        gnt = '0;
        idx = 0;
        // Walk from farthest to nearest so the nearest requester overwrites.
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/qa_drv_wr_sched.sv
// qa_drv_wr_sched: round-robin CCI write scheduler with fences and outstanding-write tracking.
// Define QA_DRV_WR_SCHED_STATUS_PRIO_EN to give requester 0 (status writer) strict priority.
module qa_drv_wr_sched
    import qa_drv_pkg::*;
#(
    parameter int N_REQ           = 3,
    parameter int TXHDR_WIDTH     = 61,
    parameter int CACHE_WIDTH     = 512,
    parameter int MAX_OUTSTANDING = QA_DRV_MAX_OUTSTANDING
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_REQ-1:0]                       req,
    input  logic [N_REQ-1:0]                       fence,
    input  logic [N_REQ*TXHDR_WIDTH-1:0]           hdr,
    input  logic [N_REQ*CACHE_WIDTH-1:0]           data,
    output logic [N_REQ-1:0]                       grant,
    input  logic                                   tx1_almostfull,
    input  logic                                   rx0_wrvalid,
    input  logic                                   rx1_wrvalid,
    output logic [TXHDR_WIDTH-1:0]                 tx1_header,
    output logic [CACHE_WIDTH-1:0]                 tx1_data,
    output logic                                   tx1_wrvalid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   idle,
    output logic                                   underflow_err
);
    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    t_WR_SCHED_STATE        state_q, state_d;
    logic [LW-1:0]          last_grant_q, last_grant_d;
    logic [LW-1:0]          lock_q, lock_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic                   underflow_err_q, underflow_err_d;
    logic                   tx1_wrvalid_q, tx1_wrvalid_d;
    logic [TXHDR_WIDTH-1:0] tx1_header_q, tx1_header_d;
    logic [CACHE_WIDTH-1:0] tx1_data_q, tx1_data_d;

    logic [N_REQ-1:0] rr_req, rr_gnt, win;
    logic [LW-1:0]    win_idx, gnt_idx;
    logic [OW:0]      inc;
    logic [1:0]       resp;
    logic             prio, can_issue, upd_last, issue, under;

`ifdef QA_DRV_WR_SCHED_STATUS_PRIO_EN
    assign prio   = req[0];
    assign rr_req = req & ~N_REQ'(1);
`else
    assign prio   = 1'b0;
    assign rr_req = req;
`endif

    qa_drv_rr_picker #(.N(N_REQ), .LW(LW)) u_pick (
        .req  (rr_req),
        .last (last_grant_q),
        .gnt  (rr_gnt)
    );

    assign win = prio ? N_REQ'(1) : rr_gnt;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win[i]) win_idx = LW'(i);
        can_issue = !tx1_almostfull && (outstanding_q < OW'(MAX_OUTSTANDING));
        state_d   = state_q;
        lock_d    = lock_q;
        grant     = '0;
        gnt_idx   = win_idx;
        upd_last  = 1'b0;
        if (state_q == ARB) begin
            if (|win) begin
                if (fence[win_idx] && outstanding_q != '0) begin
                    state_d = FENCE_WAIT;
                    lock_d  = win_idx;
                end else if (can_issue) begin
                    grant    = win;
                    upd_last = !prio;
                end
            end
        end else if (outstanding_q == '0 && can_issue && req[lock_q]) begin
            grant    = N_REQ'(1) << lock_q;
            gnt_idx  = lock_q;
            upd_last = 1'b1;
            state_d  = ARB;
        end
        if (reset) grant = '0;
        issue        = |grant;
        last_grant_d = upd_last ? gnt_idx : last_grant_q;
        // Responses beyond what is in flight saturate at zero and flag underflow.
        inc             = {1'b0, outstanding_q} + (OW+1)'(issue);
        resp            = {1'b0, rx0_wrvalid} + {1'b0, rx1_wrvalid};
        under           = inc < (OW+1)'(resp);
        outstanding_d   = under ? '0 : OW'(inc - (OW+1)'(resp));
        underflow_err_d = underflow_err_q | under;
        tx1_wrvalid_d   = issue;
        tx1_header_d    = hdr[int'(gnt_idx)*TXHDR_WIDTH +: TXHDR_WIDTH];
        tx1_data_d      = data[int'(gnt_idx)*CACHE_WIDTH +: CACHE_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ARB;
            last_grant_q    <= LW'(N_REQ - 1);
            lock_q          <= '0;
            outstanding_q   <= '0;
            underflow_err_q <= 1'b0;
            tx1_wrvalid_q   <= 1'b0;
            tx1_header_q    <= '0;
            tx1_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            lock_q          <= lock_d;
            outstanding_q   <= outstanding_d;
            underflow_err_q <= underflow_err_d;
            tx1_wrvalid_q   <= tx1_wrvalid_d;
            tx1_header_q    <= tx1_header_d;
            tx1_data_q      <= tx1_data_d;
        end
    end

    assign tx1_wrvalid   = tx1_wrvalid_q;
    assign tx1_header    = tx1_header_q;
    assign tx1_data      = tx1_data_q;
    assign outstanding   = outstanding_q;
    assign underflow_err = underflow_err_q;
    assign idle          = (outstanding_q == '0) && !(|req) && (state_q == ARB);
endmodule

// File: tb/tb_qa_drv_wr_sched.sv
// tb_qa_drv_wr_sched: directed self-checking bench for qa_drv_wr_sched.
module tb_qa_drv_wr_sched;
    localparam int N  = 3;
    localparam int HW = 61;
    localparam int CW = 512;
`ifdef QA_DRV_WR_SCHED_STATUS_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, fence, grant;
    logic [N*HW-1:0] hdr;
    logic [N*CW-1:0] data;
    logic            tx1_almostfull, rx0_wrvalid, rx1_wrvalid;
    logic [HW-1:0]   tx1_header;
    logic [CW-1:0]   tx1_data;
    logic            tx1_wrvalid, idle, underflow_err;
    logic [6:0]      outstanding;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    qa_drv_wr_sched dut (
        .clk(clk), .reset(reset), .req(req), .fence(fence), .hdr(hdr), .data(data),
        .grant(grant), .tx1_almostfull(tx1_almostfull), .rx0_wrvalid(rx0_wrvalid),
        .rx1_wrvalid(rx1_wrvalid), .tx1_header(tx1_header), .tx1_data(tx1_data),
        .tx1_wrvalid(tx1_wrvalid), .outstanding(outstanding), .idle(idle),
        .underflow_err(underflow_err)
    );

    function automatic logic [HW-1:0] hv(input int i);
        return HW'(i) + HW'(61'h1A0);
    endfunction

    function automatic logic [CW-1:0] dv(input int i);
        return CW'(i) + CW'(32'hDA7A0);
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = '0; fence = '0;
        tx1_almostfull = 1'b0; rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            hdr[i*HW +: HW]  = hv(i);
            data[i*CW +: CW] = dv(i);
        end
        repeat (2) tick;
        req = '1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_wrvalid", tx1_wrvalid, 0);
        chk("rst_header", tx1_header, 0);
        chk("rst_data", tx1_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_underflow", underflow_err, 0);
        reset = 1'b0; req = '0;
        tick;
        #1 chk("idle_after_rst", idle, 1);

        // Round-robin 0,1,2,0 with responses returning one cycle after issue
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            rx0_wrvalid = tx1_wrvalid;
            #1 chk("rr_grant", grant, PRIO_EN ? 3'b001 : 3'(1 << (k % 3)));
            tick;
            chk("rr_wrvalid", tx1_wrvalid, 1);
            chk("rr_header", tx1_header, hv(PRIO_EN ? 0 : k % 3));
            chk("rr_data", tx1_data, dv(PRIO_EN ? 0 : k % 3));
        end
        req = '0;
        rx0_wrvalid = tx1_wrvalid;
        #1 chk("rr_nogrant", grant, 0);
        tick;
        rx0_wrvalid = 1'b0;
        chk("rr_wrvalid_drop", tx1_wrvalid, 0);
        chk("rr_outstanding", outstanding, 0);
        #1 chk("rr_idle", idle, 1);

        // Fill to MAX_OUTSTANDING, then one response frees a slot
        req = 3'b001;
        repeat (64) tick;
        #1;
        chk("full_outstanding", outstanding, 64);
        chk("full_grant", grant, 0);
        rx1_wrvalid = 1'b1;
        #1 chk("full_grant_resp_cycle", grant, 0);
        tick;
        rx1_wrvalid = 1'b0;
        chk("full_after_resp", outstanding, 63);
        #1 chk("full_regrant", grant, 3'b001);
        tick;
        chk("full_refill", outstanding, 64);
        #1 chk("full_grant_again", grant, 0);
        req = '0; rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        repeat (32) tick;
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("full_drain", outstanding, 0);
        chk("full_no_underflow", underflow_err, 0);

        // Fence with writes in flight
        req = 3'b001;
        repeat (3) tick;
        req = '0;
        chk("fence_pre_outstanding", outstanding, 3);
        req = PRIO_EN ? 3'b110 : 3'b111; fence = 3'b010;
        #1 chk("fence_enter", grant, 0);
        tick;
        #1 chk("fence_wait_grant", grant, 0);
        chk("fence_wait_idle", idle, 0);
        for (int k = 0; k < 3; k++) begin
            rx0_wrvalid = 1'b1;
            #1 chk("fence_drain_grant", grant, 0);
            tick;
            rx0_wrvalid = 1'b0;
        end
        chk("fence_drained", outstanding, 0);
        #1 chk("fence_release", grant, 3'b010);
        tick;
        chk("fence_header", tx1_header, hv(1));
        chk("fence_issue_count", outstanding, 1);
        req = PRIO_EN ? 3'b100 : 3'b101; fence = '0;
        #1 chk("fence_next_rr", grant, 3'b100);
        tick;
        req = '0; rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        tick;
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("fence_post_drain", outstanding, 0);

        // Issue plus two responses in one cycle
        req = 3'b001;
        repeat (5) tick;
        chk("net_pre", outstanding, 5);
        rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        #1 chk("net_grant", grant, 3'b001);
        tick;
        req = '0;
        chk("net_minus1", outstanding, 4);
        repeat (2) tick;
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("net_drain", outstanding, 0);
        chk("net_no_underflow", underflow_err, 0);

        // Underflow is sticky until reset
        rx0_wrvalid = 1'b1;
        tick;
        rx0_wrvalid = 1'b0;
        chk("uf_saturate", outstanding, 0);
        chk("uf_set", underflow_err, 1);
        repeat (3) tick;
        chk("uf_sticky", underflow_err, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("uf_cleared", underflow_err, 0);

        // Reset while in FENCE_WAIT drops the lock; late response underflows
        req = 3'b001;
        repeat (2) tick;
        req = 3'b010; fence = 3'b010;
        #1 chk("rfw_enter", grant, 0);
        tick;
        reset = 1'b1; req = '0; fence = '0;
        tick;
        reset = 1'b0;
        chk("rfw_outstanding", outstanding, 0);
        rx0_wrvalid = 1'b1;
        tick;
        rx0_wrvalid = 1'b0;
        chk("rfw_late_resp", underflow_err, 1);
        chk("rfw_saturate", outstanding, 0);
        req = 3'b010; fence = 3'b010;
        #1 chk("fence_zero_grant", grant, 3'b010);
        tick;
        req = '0; fence = '0;
        chk("fence_zero_count", outstanding, 1);

        // Almost-full blocks everything; then status priority or plain RR
        tx1_almostfull = 1'b1; req = 3'b111;
        #1 chk("af_grant", grant, 0);
        tick;
        chk("af_wrvalid", tx1_wrvalid, 0);
        #1 chk("af_grant2", grant, 0);
        tick;
        chk("af_wrvalid2", tx1_wrvalid, 0);
        tx1_almostfull = 1'b0; req = 3'b101;
        #1 chk("pr_grant0", grant, PRIO_EN ? 3'b001 : 3'b100);
        tick;
        #1 chk("pr_grant1", grant, 3'b001);
        tick;
        #1 chk("pr_grant2", grant, PRIO_EN ? 3'b001 : 3'b100);
        tick;
        req = '0;
        chk("pr_count", outstanding, 4);
        rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        repeat (2) tick;
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("pr_drain", outstanding, 0);
        #1 chk("final_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/qa_drv_wr_sched.md
QA_DRV_WR_SCHED -- requirements
Module: qa_drv_wr_sched

Interface
REQ-001 SHALL have parameters, one per line:
- N_REQ, 3, number of write requesters (index 0 = status writer).
- TXHDR_WIDTH, 61, CCI TX header width.
- CACHE_WIDTH, 512, cache line width.
- MAX_OUTSTANDING, 64, maximum write requests in flight.
REQ-002 SHALL have ports, one per line:
- clk  in  1  CCI clock; one clock only, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester write request.
- fence  in  N_REQ  request must issue only after all prior writes complete.
- hdr  in  N_REQ*TXHDR_WIDTH  per-requester header, packed, requester i at slice i.
- data  in  N_REQ*CACHE_WIDTH  per-requester line, packed.
- grant  out  N_REQ  one-hot accept pulse.
- tx1_almostfull  in  1  CCI channel 1 almost full.
- rx0_wrvalid  in  1  write response on channel 0.
- rx1_wrvalid  in  1  write response on channel 1.
- tx1_header  out  TXHDR_WIDTH  registered CCI write header.
- tx1_data  out  CACHE_WIDTH  registered CCI write data.
- tx1_wrvalid  out  1  registered CCI write valid.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  writes in flight.
- idle  out  1  outstanding==0, no req, state ARB.
- underflow_err  out  1  sticky: response received with outstanding==0.

Function
REQ-003 SHALL issue only when tx1_almostfull==0 and outstanding<MAX_OUTSTANDING (this condition is "can_issue").
REQ-004 SHALL assert grant[i] combinationally in cycle N for the arbitration winner; tx1_* SHALL carry hdr/data slice i with tx1_wrvalid=1 in cycle N+1 (latency 1).
REQ-005 SHALL grant at most one requester per cycle; tx1_wrvalid SHALL be 0 in any cycle following a cycle with no grant.
REQ-006 SHALL arbitrate round-robin: search from (last_grant+1) mod N_REQ; last_grant SHALL update only on a grant and SHALL reset to N_REQ-1.
REQ-007 SHALL use states ARB and FENCE_WAIT. In ARB, if the winner has fence=1 and outstanding!=0, the block SHALL enter FENCE_WAIT, lock that requester, and emit no grant.
REQ-008 In FENCE_WAIT, grants to all requesters SHALL be suppressed. When outstanding==0 and can_issue, the block SHALL grant the locked requester and return to ARB in the same cycle.
REQ-009 In ARB, a fence request with outstanding==0 SHALL be granted like any other request.
REQ-010 Requesters SHALL hold req/fence/hdr/data stable until granted; the block SHALL NOT check this.
REQ-011 outstanding next value SHALL be outstanding + issue - rx0_wrvalid - rx1_wrvalid. A simultaneous issue and two responses SHALL yield a net change of -1.
REQ-012 outstanding SHALL saturate at 0. Any response that would underflow SHALL set underflow_err until reset.
REQ-013 outstanding SHALL never exceed MAX_OUTSTANDING. A response arriving in the cycle where outstanding reaches MAX_OUTSTANDING SHALL allow issue on the next cycle.

Reset
REQ-014 On reset the block SHALL set: state=ARB, grant=0, tx1_wrvalid=0, tx1_header=0, tx1_data=0, outstanding=0, underflow_err=0, last_grant=N_REQ-1.
REQ-015 Reset mid-FENCE_WAIT SHALL drop the lock; in-flight responses arriving after reset SHALL saturate and set underflow_err.

Configuration
REQ-016 With QA_DRV_WR_SCHED_STATUS_PRIO_EN defined, requester 0 SHALL win whenever req[0]=1 and the block is not in FENCE_WAIT, and this win SHALL NOT update last_grant; requesters 1..N_REQ-1 SHALL arbitrate round-robin. Without the macro, all requesters SHALL arbitrate round-robin.

Structure
REQ-017 The shared qa_drv package SHALL hold t_WR_SCHED_STATE (ARB, FENCE_WAIT) and the MAX_OUTSTANDING default constant.
REQ-018 The round-robin search SHALL be the sub-module qa_drv_rr_picker (request vector, last-grant pointer in; one-hot winner out).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- req=3'b111 held, almostfull=0, responses immediate -> grants in order 0,1,2,0; tx1_wrvalid each cycle one cycle after grant.
- 64 issues with no responses -> outstanding=64 and grant held 0; one rx1_wrvalid -> grant on next cycle, outstanding back to 64.
- outstanding=3, req[1] with fence=1 -> FENCE_WAIT, no grants to req[0]/req[2]; three responses -> grant[1] when outstanding==0.
- issue plus rx0_wrvalid and rx1_wrvalid in the same cycle from outstanding=5 -> outstanding=4.
- outstanding=0, rx0_wrvalid=1 -> outstanding stays 0, underflow_err=1 until reset.
- tx1_almostfull=1 with req=3'b111 -> no grant, tx1_wrvalid=0; with the macro, req[0] and req[2] -> grant[0] every cycle.
